ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter width_p, default 8, data word width in bits.
REQ-002 SHALL have parameter depth_p, default 8, number of RAM words; any value >= 2, not required to be a power of two.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, reset; synchronous and active-low (0 = reset).
REQ-005 SHALL have port cmd_valid_i, input, 1, read command offered.
REQ-006 SHALL have port cmd_ready_o, output, 1, command accepted when high together with cmd_valid_i.
REQ-007 SHALL have port cmd_addr_i, input, $clog2(depth_p), start word address.
REQ-008 SHALL have port cmd_len_i, input, $clog2(depth_p+1), number of words to read (0..depth_p).
REQ-009 SHALL have port rd_addr_o, output, $clog2(depth_p), drives the RAM asynchronous read address.
REQ-010 SHALL have port rd_data_i, input, width_p, combinational RAM read data for rd_addr_o.
REQ-011 SHALL have port data_valid_o, output, 1, stream word valid.
REQ-012 SHALL have port data_ready_i, input, 1, downstream ready.
REQ-013 SHALL have port data_o, output, width_p, stream word.
REQ-014 SHALL have port last_o, output, 1, marks the final word of a command.
REQ-015 SHALL have port done_o, output, 1, one-cycle pulse when a command completes.

Function
REQ-016 SHALL implement FSM states IDLE and RUN; cmd_ready_o is high only in IDLE.
REQ-017 SHALL, in IDLE, on cmd_valid_i && cmd_ready_o with cmd_len_i > 0, latch the address and length and go to RUN.
REQ-018 SHALL, on acceptance with cmd_len_i == 0, stay in IDLE, produce no stream word, and pulse done_o in the following cycle.
REQ-019 SHALL register each word: data_o captures rd_data_i at the edge on which the output register loads; the first word is valid one cycle after command acceptance.
REQ-020 SHALL load the output register whenever words remain and (data_valid_o == 0 or data_ready_i == 1), giving a sustained rate of 1 word per cycle under constant ready.
REQ-021 SHALL hold data_o, last_o and data_valid_o stable while data_valid_o && !data_ready_i.
REQ-022 SHALL advance the read address by 1 per loaded word, wrapping from depth_p-1 to 0.
REQ-023 SHALL assert last_o with the word that exhausts the remaining count.
REQ-024 SHALL, when the last word handshakes, return to IDLE with data_valid_o low and pulse done_o in the same cycle as that handshake; a new command is accepted the next cycle.
REQ-025 SHALL, when the RAM is written in the same cycle at rd_addr_o, return the pre-write contents to the stream.
REQ-026 SHALL ignore cmd_valid_i outside IDLE; the command is neither latched nor dropped silently, since cmd_ready_o is low.

Reset
REQ-027 SHALL, while reset_i == 0 at a rising edge, enter IDLE and clear data_valid_o, last_o, done_o, the address, and the count to 0; data_o is cleared to 0.
REQ-028 SHALL abort an in-flight command on reset without asserting done_o; cmd_ready_o is high in the first cycle after reset deasserts.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, RUN) in a shared package ram_stream_reader_pkg.
REQ-030 SHALL contain no sub-modules; the bench pairs it with the team's async-read 1R1W RAM (width 8, depth 8).

Verification
REQ-031 The bench SHALL drive RAM init mem[i]=0x10+i, cmd addr=2 len=3 with ready held high -> data 0x12, 0x13, 0x14 on consecutive cycles; last_o on 0x14; done_o pulses with the 0x14 handshake.
REQ-032 The bench SHALL drive cmd addr=6 len=4 -> data 0x16, 0x17, 0x10, 0x11 (wrap at 7->0).
REQ-033 The bench SHALL drive cmd addr=0 len=8 with data_ready_i toggling 1,0,1,0 -> all 8 words in order, with no duplicates or drops and data_o stable during stalls.
REQ-034 The bench SHALL drive cmd len=0 -> no data_valid_o; done_o pulses once, one cycle after acceptance.
REQ-035 The bench SHALL write mem[3]=0xAA in the same cycle the reader presents rd_addr_o=3 -> stream outputs 0x13, and a later read of address 3 outputs 0xAA.
REQ-036 The bench SHALL drive reset_i=0 mid-command (after 2 of 5 words) -> data_valid_o=0 next cycle, no done_o, cmd_ready_o=1 after release, and a new command runs correctly.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared types for the RAM stream reader: FSM state encoding and address wrap helper.
package ram_stream_reader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Increment a word address modulo an arbitrary (non power-of-two) depth.
    function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
        return (addr + 1 >= depth) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/ram_stream_reader.sv
// Streams a run of words out of an async-read RAM as a valid/ready stream,
// one registered word per cycle, wrapping the read address at the RAM depth.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int width_p = 8,
    parameter int depth_p = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [$clog2(depth_p)-1:0]   cmd_addr_i,
    input  logic [$clog2(depth_p+1)-1:0] cmd_len_i,
    output logic [$clog2(depth_p)-1:0]   rd_addr_o,
    input  logic [width_p-1:0]           rd_data_i,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output logic [width_p-1:0]           data_o,
    output logic                         last_o,
    output logic                         done_o
);

    localparam int aw_lp = $clog2(depth_p);
    localparam int lw_lp = $clog2(depth_p + 1);

    state_e             state_q, state_d;
    logic [aw_lp-1:0]   addr_q,  addr_d;
    logic [lw_lp-1:0]   cnt_q,   cnt_d;
    logic [width_p-1:0] data_q,  data_d;
    logic               valid_q, valid_d;
    logic               last_q,  last_d;
    logic               done_q,  done_d;
    logic               load;
    logic               hs;

    // In IDLE the RAM is addressed straight from the command so the first
    // word can be registered on the accepting edge.
    assign rd_addr_o    = (state_q == IDLE) ? cmd_addr_i : addr_q;
    assign cmd_ready_o  = (state_q == IDLE);
    assign data_valid_o = valid_q;
    assign data_o       = data_q;
    assign last_o       = last_q;
    assign hs           = valid_q && data_ready_i;
    assign done_o       = done_q || (hs && last_q);
    assign load         = (state_q == RUN) && (cnt_q != '0) && (!valid_q || data_ready_i);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        data_d  = rd_data_i;
                        valid_d = 1'b1;
                        last_d  = (cmd_len_i == lw_lp'(1));
                        addr_d  = aw_lp'(wrap_inc(int'(cmd_addr_i), depth_p));
                        cnt_d   = cmd_len_i - lw_lp'(1);
                    end
                end
            end
            RUN: begin
                if (load) begin
                    data_d  = rd_data_i;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == lw_lp'(1));
                    addr_d  = aw_lp'(wrap_inc(int'(addr_q), depth_p));
                    cnt_d   = cnt_q - lw_lp'(1);
                end else if (hs) begin
                    // Nothing left to load, so this handshake is the last word.
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader paired with a behavioural async-read 1R1W RAM.
module tb_ram_stream_reader;

    localparam int D = 8;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [2:0] cmd_addr_i = '0;
    logic [3:0] cmd_len_i = '0;
    logic [2:0] rd_addr_o;
    logic [7:0] rd_data_i;
    logic       data_valid_o;
    logic       data_ready_i = 1'b0;
    logic [7:0] data_o;
    logic       last_o;
    logic       done_o;

    logic [7:0] mem [D];
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] ref_mem [D];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    assign rd_data_i = mem[rd_addr_o];
    always @(posedge clk_i) if (we) mem[waddr] <= wdata;

    ram_stream_reader #(.width_p(8), .depth_p(D)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .data_o(data_o), .last_o(last_o), .done_o(done_o)
    );

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < D; i++) begin
            @(negedge clk_i);
            we = 1'b1;
            waddr = 3'(i);
            wdata = rnd ? 8'($urandom) : 8'(16 + i);
            ref_mem[i] = wdata;
        end
        @(negedge clk_i);
        we = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b expected 0", data_valid_o); end
        n_cmp++; if (last_o !== 1'b0) begin n_err++; $display("FAIL reset_last got %b expected 0", last_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b expected 0", done_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_err++; $display("FAIL reset_data got %h expected 00", data_o); end
        reset_i = 1'b1;
        @(negedge clk_i);
        #1;
        n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got %b expected 1", cmd_ready_o); end
    endtask

    // mode 0: ready held high, 1: ready toggles 1,0,1,0.., 2: random ready
    task automatic test_stream(input int a, input int l, input int mode, input string nm);
        logic [7:0] exp [$];
        logic [7:0] prev_data;
        bit         prev_stall;
        int         idx;
        int         cyc;
        @(negedge clk_i);
        #1;
        n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL %s cmd_ready got %b expected 1", nm, cmd_ready_o); end
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL %s idle_valid got %b expected 0", nm, data_valid_o); end
        for (int i = 0; i < l; i++) exp.push_back(ref_mem[(a + i) % D]);
        cmd_valid_i = 1'b1;
        cmd_addr_i = 3'(a);
        cmd_len_i = 4'(l);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        idx = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        while (idx < l && cyc < 200) begin
            case (mode)
                0: data_ready_i = 1'b1;
                1: data_ready_i = (cyc % 2 == 0);
                default: data_ready_i = 1'($urandom);
            endcase
            #1;
            if (cyc == 0) begin
                n_cmp++; if (data_valid_o !== 1'b1) begin n_err++; $display("FAIL %s first_latency valid got %b expected 1", nm, data_valid_o); end
            end
            if (data_valid_o === 1'b1) begin
                n_cmp++; if (data_o !== exp[idx]) begin n_err++; $display("FAIL %s data[%0d] got %h expected %h", nm, idx, data_o, exp[idx]); end
                n_cmp++; if (last_o !== (idx == l - 1)) begin n_err++; $display("FAIL %s last[%0d] got %b expected %b", nm, idx, last_o, idx == l - 1); end
                if (prev_stall) begin
                    n_cmp++; if (data_o !== prev_data) begin n_err++; $display("FAIL %s stall_hold got %h expected %h", nm, data_o, prev_data); end
                end
                n_cmp++; if (done_o !== (data_ready_i && idx == l - 1)) begin n_err++; $display("FAIL %s done[%0d] got %b expected %b", nm, idx, done_o, data_ready_i && idx == l - 1); end
                prev_stall = !data_ready_i;
                prev_data = data_o;
                if (data_ready_i) idx++;
            end else begin
                n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL %s done_early got %b expected 0", nm, done_o); end
                if (mode == 0) begin
                    n_cmp++; n_err++; $display("FAIL %s bubble at cycle %0d got valid 0 expected 1", nm, cyc);
                end
                prev_stall = 1'b0;
            end
            cyc++;
            if (idx < l) @(negedge clk_i);
        end
        n_cmp++; if (idx != l) begin n_err++; $display("FAIL %s timeout got %0d words expected %0d", nm, idx, l); end
        if (mode == 0) begin
            n_cmp++; if (cyc != l) begin n_err++; $display("FAIL %s rate got %0d cycles expected %0d", nm, cyc, l); end
        end
    endtask

    task automatic test_basic();
        fill_mem(1'b0);
        test_stream(2, 3, 0, "basic");
    endtask

    task automatic test_wrap();
        test_stream(6, 4, 0, "wrap");
    endtask

    task automatic test_toggle();
        test_stream(0, 8, 1, "toggle");
    endtask

    task automatic test_len0();
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_addr_i = 3'd5;
        cmd_len_i = 4'd0;
        data_ready_i = 1'b1;
        #1;
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL len0 done_accept got %b expected 0", done_o); end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        #1;
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL len0 done got %b expected 1", done_o); end
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL len0 valid got %b expected 0", data_valid_o); end
        n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL len0 cmd_ready got %b expected 1", cmd_ready_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            n_cmp++; if (done_o !== 1'b0 || data_valid_o !== 1'b0) begin n_err++; $display("FAIL len0 after got done %b valid %b expected 0 0", done_o, data_valid_o); end
        end
    endtask

    task automatic test_same_cycle_write();
        logic [7:0] e;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_addr_i = 3'd3;
        cmd_len_i = 4'd1;
        we = 1'b1;
        waddr = 3'd3;
        wdata = 8'hAA;
        #1;
        n_cmp++; if (rd_addr_o !== 3'd3) begin n_err++; $display("FAIL wr_rd rd_addr got %0d expected 3", rd_addr_o); end
        e = ref_mem[3];
        ref_mem[3] = 8'hAA;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        we = 1'b0;
        data_ready_i = 1'b1;
        #1;
        n_cmp++; if (data_valid_o !== 1'b1 || data_o !== e) begin n_err++; $display("FAIL wr_rd old_data got %b/%h expected 1/%h", data_valid_o, data_o, e); end
        n_cmp++; if (last_o !== 1'b1 || done_o !== 1'b1) begin n_err++; $display("FAIL wr_rd last_done got %b%b expected 11", last_o, done_o); end
        test_stream(3, 1, 0, "wr_rd_new");
    endtask

    task automatic test_reset_mid();
        int hs;
        int cyc;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_addr_i = 3'd1;
        cmd_len_i = 4'd5;
        data_ready_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        hs = 0;
        cyc = 0;
        while (hs < 2 && cyc < 20) begin
            #1;
            if (data_valid_o === 1'b1) begin
                n_cmp++; if (data_o !== ref_mem[1 + hs]) begin n_err++; $display("FAIL rstmid data got %h expected %h", data_o, ref_mem[1 + hs]); end
                hs++;
            end
            n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rstmid done_pre got %b expected 0", done_o); end
            cyc++;
            @(negedge clk_i);
        end
        n_cmp++; if (hs != 2) begin n_err++; $display("FAIL rstmid timeout got %0d expected 2", hs); end
        reset_i = 1'b0;
        @(negedge clk_i);
        #1;
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid valid got %b expected 0", data_valid_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rstmid done got %b expected 0", done_o); end
        n_cmp++; if (last_o !== 1'b0 || data_o !== 8'h00) begin n_err++; $display("FAIL rstmid clear got %b/%h expected 0/00", last_o, data_o); end
        reset_i = 1'b1;
        test_stream(4, 5, 1, "rstmid_new");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            if (n % 5 == 0) fill_mem(1'b1);
            test_stream(int'($urandom_range(0, D - 1)), int'($urandom_range(1, D)),
                        int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_toggle();
        test_len0();
        test_same_cycle_write();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
